// File: rtl/isa_dispatch.sv
// Instruction sequencer: fetches and decodes one 32-bit instruction, then enables one execution unit
// until it finishes. The core stops on HALT, on an illegal opcode, or on a watchdog timeout.
module isa_dispatch #(
    parameter int N_UNITS         = 8,
    parameter int PC_WIDTH        = 16,
    parameter int RESET_PC        = 0,
    parameter int MAX_EXEC_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [31:0]         imem_data,
    output logic [N_UNITS-1:0]  unit_en,
    input  logic [N_UNITS-1:0]  unit_finished,
    output logic [3:0]          r0,
    output logic [3:0]          r1,
    output logic [15:0]         imm,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_RELEASE,
        S_HALTED,
        S_TRAP
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_RESET = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);
    localparam logic [7:0]          WD_LAST  = 8'(MAX_EXEC_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] instr;
    logic [7:0]  opcode;
    logic [7:0]  wdog;
    logic        op_is_unit;
    logic        op_is_halt;
    logic        unit_done;
    logic        wdog_expired;

    assign opcode       = instr[31:24];
    assign op_is_halt   = (opcode == 8'hFF);
    assign op_is_unit   = (32'(opcode) < N_UNITS);
    // unit_en is one-hot on the current opcode, so this picks only that unit's flag.
    assign unit_done    = |(unit_finished & unit_en);
    assign wdog_expired = (wdog == WD_LAST);
    assign imem_addr    = pc;

    always_comb begin
        unit_en = '0;
        if (state == S_EXEC) begin
            for (int i = 0; i < N_UNITS; i++) begin
                unit_en[i] = (32'(opcode) == i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:   if (imem_req && imem_ack) state_nxt = S_DECODE;
            S_DECODE: begin
                if (op_is_unit)      state_nxt = S_EXEC;
                else if (op_is_halt) state_nxt = S_HALTED;
                else                 state_nxt = S_TRAP;
            end
            S_EXEC: begin
                if (unit_done)         state_nxt = S_RELEASE;
                else if (wdog_expired) state_nxt = S_TRAP;
            end
            S_RELEASE: state_nxt = S_FETCH;
            default:   state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= PC_RESET;
            imem_req   <= 1'b0;
            r0         <= '0;
            r1         <= '0;
            imm        <= '0;
            halted     <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
            wdog       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_FETCH: begin
                    // Right after reset the request is still low; raise it before accepting an ack.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instr    <= imem_data;
                        imem_req <= 1'b0;
                    end
                end
                S_DECODE: begin
                    r0  <= instr[23:20];
                    r1  <= instr[19:16];
                    imm <= instr[15:0];
                    if (!op_is_unit && op_is_halt) halted <= 1'b1;
                    if (!op_is_unit && !op_is_halt) begin
                        trap       <= 1'b1;
                        trap_cause <= 2'd1;
                    end
                end
                S_EXEC: begin
                    if (!unit_done) begin
                        if (wdog_expired) begin
                            trap       <= 1'b1;
                            trap_cause <= 2'd2;
                        end else begin
                            wdog <= wdog + 8'd1;
                        end
                    end
                end
                S_RELEASE: begin
                    pc       <= pc + PC_ONE;
                    wdog     <= '0;
                    imem_req <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
